// File: rtl/fc_ibuf.sv
// Activation input buffer: gathers the func unit's parallel writes, then streams bit-planes LSB first.
// Optional FC_IBUF_CLEAR_EN: zero all storage when a stream finishes.
module fc_ibuf #(
  parameter int DATA_SIZE     = 8,
  parameter int INPUT_NEURONS = 512,
  parameter int XBAR_SIZE     = 256,
  parameter int PREV_H_TILES  = 16,
  parameter int NUM_CHANNELS  = 1,
  localparam int EPT   = XBAR_SIZE / DATA_SIZE,
  localparam int WR_NUM_ADDR = (EPT + NUM_CHANNELS - 1) / NUM_CHANNELS,
  localparam int V_CIM_TILES = (INPUT_NEURONS + XBAR_SIZE - 1) / XBAR_SIZE,
  localparam int BIT_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1,
  localparam int WA_W  = $clog2(WR_NUM_ADDR + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_SIZE-1:0]  i_data [PREV_H_TILES-1:0][NUM_CHANNELS-1:0],
  input  logic                  i_write_enable,
  input  logic                  i_start,
  output logic                  o_ready,
  input  logic                  i_cim_ready,
  output logic [V_CIM_TILES-1:0][XBAR_SIZE-1:0] o_cim_data,
  output logic                  o_cim_valid,
  output logic [BIT_W-1:0]      o_bit_idx,
  output logic                  o_cim_last
);

  typedef enum logic [1:0] {
    S_FILL,
    S_WAIT,
    S_STREAM
  } state_e;

  state_e            state_q, state_d;
  logic [WA_W-1:0]   wr_addr_q, wr_addr_d;
  logic [BIT_W-1:0]  bit_idx_q, bit_idx_d;
  logic              fill_w, stream_w, last_w, wr_go, clr;
  logic [DATA_SIZE-1:0] mem [INPUT_NEURONS];

  assign fill_w   = (state_q == S_FILL);
  assign stream_w = (state_q == S_STREAM);
  assign last_w   = (bit_idx_q == BIT_W'(DATA_SIZE - 1));
  assign wr_go    = fill_w && i_write_enable;

`ifdef FC_IBUF_CLEAR_EN
  assign clr = stream_w && last_w;
`else
  assign clr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FILL;
      wr_addr_q <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    bit_idx_d = bit_idx_q;
    unique case (state_q)
      S_FILL: begin
        if (i_write_enable && wr_addr_q != WA_W'(WR_NUM_ADDR))
          wr_addr_d = wr_addr_q + 1'b1;
        if (i_start)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_cim_ready) begin
          state_d   = S_STREAM;
          bit_idx_d = '0;
        end
      end
      S_STREAM: begin
        if (last_w) begin
          state_d   = S_FILL;
          wr_addr_d = '0;
          bit_idx_d = '0;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Each element has a fixed (tile, address, channel) source lane.
  for (genvar e = 0; e < INPUT_NEURONS; e++) begin : g_el
    localparam int H   = e / EPT;
    localparam int OFF = e % EPT;
    localparam int A   = OFF / NUM_CHANNELS;
    localparam int C   = OFF % NUM_CHANNELS;
    if (H < PREV_H_TILES) begin : g_wr
      logic [DATA_SIZE-1:0] el_q;
      always_ff @(posedge clk) begin
        if (clr)
          el_q <= '0;
        else if (wr_go && wr_addr_q == WA_W'(A))
          el_q <= i_data[H][C];
      end
      assign mem[e] = el_q;
    end else begin : g_nw
      assign mem[e] = '0;
    end
  end

  for (genvar v = 0; v < V_CIM_TILES; v++) begin : g_v
    for (genvar r = 0; r < XBAR_SIZE; r++) begin : g_r
      localparam int ROW = v * XBAR_SIZE + r;
      if (ROW < INPUT_NEURONS) begin : g_on
        assign o_cim_data[v][r] = stream_w & mem[ROW][bit_idx_q];
      end else begin : g_pad
        assign o_cim_data[v][r] = 1'b0;
      end
    end
  end

  assign o_ready     = fill_w;
  assign o_cim_valid = stream_w;
  assign o_cim_last  = stream_w && last_w;
  assign o_bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_fc_ibuf.sv
// Scoreboard bench for fc_ibuf: full (8) and padded (6) neuron instances share stimulus.
// Honours FC_IBUF_CLEAR_EN for the partial-refill expectations.
module tb_fc_ibuf;

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [2:0]  b;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  din [1:0][0:0];
  logic        we, st, cim_rdy;
  logic        rdy0, rdy1, vld0, vld1, last0, last1;
  logic [0:0][31:0] cd0, cd1;
  logic [2:0]  bi0, bi1;

  int n_chk = 0;
  int n_fail = 0;
  int wcnt = 0;
  logic [7:0] mem_m [8];
  exp_t q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  fc_ibuf #(.DATA_SIZE(8), .INPUT_NEURONS(8), .XBAR_SIZE(32),
            .PREV_H_TILES(2), .NUM_CHANNELS(1)) u_full (
    .clk(clk), .rst(rst), .i_data(din), .i_write_enable(we),
    .i_start(st), .o_ready(rdy0), .i_cim_ready(cim_rdy),
    .o_cim_data(cd0), .o_cim_valid(vld0), .o_bit_idx(bi0),
    .o_cim_last(last0)
  );

  fc_ibuf #(.DATA_SIZE(8), .INPUT_NEURONS(6), .XBAR_SIZE(32),
            .PREV_H_TILES(2), .NUM_CHANNELS(1)) u_pad (
    .clk(clk), .rst(rst), .i_data(din), .i_write_enable(we),
    .i_start(st), .o_ready(rdy1), .i_cim_ready(cim_rdy),
    .o_cim_data(cd1), .o_cim_valid(vld1), .o_bit_idx(bi1),
    .o_cim_last(last1)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] plane(input int b, input int n);
    logic [31:0] p;
    p = '0;
    for (int r = 0; r < n; r++) p[r] = mem_m[r][b];
    return p;
  endfunction

  always @(negedge clk) begin
    if (vld0) begin
      if (q.size() == 0) begin
        check("unexpected_plane", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("plane_full", cd0, mon_e.d0);
        check("plane_pad", cd1, mon_e.d1);
        check("bit_idx", bi0, mon_e.b);
        check("last", last0, mon_e.l);
        check("pad_valid", vld1, 1);
        check("pad_last", last1, mon_e.l);
      end
    end else begin
      check("idle_data", cd0, 0);
      check("idle_last", last0, 0);
    end
  end

  task automatic wr(input logic [7:0] d0, input logic [7:0] d1,
                    input bit s);
    din[0][0] = d0;
    din[1][0] = d1;
    we = 1'b1;
    st = s;
    if (wcnt < 4) begin
      mem_m[wcnt] = d0;
      mem_m[4 + wcnt] = d1;
      wcnt++;
    end
    @(negedge clk);
    we = 1'b0;
    st = 1'b0;
  endtask

  task automatic push_planes();
    exp_t x;
    for (int b = 0; b < 8; b++) begin
      x.d0 = plane(b, 8);
      x.d1 = plane(b, 6);
      x.b  = b[2:0];
      x.l  = (b == 7);
      q.push_back(x);
    end
  endtask

  task automatic stream(input int hold);
    check("wait_rdy", rdy0, 0);
    for (int i = 0; i < hold; i++) begin
      check("bp_rdy", rdy0, 0);
      check("bp_vld", vld0, 0);
      @(negedge clk);
    end
    cim_rdy = 1'b1;
    push_planes();
    @(negedge clk);
    cim_rdy = 1'b0;
    check("first_vld", vld0, 1);
    repeat (8) @(negedge clk);
    check("rdy_back", rdy0, 1);
    check("rdy_back_pad", rdy1, 1);
    check("vld_off", vld0, 0);
    check("q_drained", q.size(), 0);
    wcnt = 0;
`ifdef FC_IBUF_CLEAR_EN
    for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
`endif
  endtask

  task automatic fill_rand();
    logic [7:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      wr(a, b, i == 3);
    end
  endtask

  initial begin
    rst = 1'b1;
    we = 1'b0;
    st = 1'b0;
    cim_rdy = 1'b0;
    din[0][0] = '0;
    din[1][0] = '0;
    repeat (2) @(negedge clk);
    check("rst_rdy", rdy0, 1);
    check("rst_vld", vld0, 0);
    check("rst_last", last0, 0);
    check("rst_bidx", bi0, 0);
    check("rst_data", cd0, 0);
    rst = 1'b0;
    @(negedge clk);

    // values 1..8, start on the 4th write, CIM ready right away
    for (int i = 0; i < 4; i++)
      wr(8'(i + 1), 8'(i + 5), i == 3);
    stream(0);

    // saturation plus 20 cycles of CIM back-pressure
    for (int i = 0; i < 6; i++)
      wr(8'(8'h10 + i * 3), 8'(8'h80 + i * 7), i == 5);
    stream(20);

    // reset during plane 3
    fill_rand();
    cim_rdy = 1'b1;
    push_planes();
    @(negedge clk);
    cim_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_bidx", bi0, 3);
    #2 rst = 1'b1;
    #1;
    check("mr_vld", vld0, 0);
    check("mr_rdy", rdy0, 1);
    check("mr_data", cd0, 0);
    check("mr_bidx", bi0, 0);
    q.delete();
    wcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_rand();
    stream(0);

    // all 0xFF, then a single write at address 0
    for (int i = 0; i < 4; i++) wr(8'hFF, 8'hFF, i == 3);
    stream(0);
    wr(8'h01, 8'h01, 1'b1);
    stream(2);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
